// File: rtl/match_controller_pkg.sv
// Shared constants for the Pong match sequencer: state encodings, score display offsets
// and the saturating score increment.
package match_controller_pkg;

  localparam logic [2:0] MS_IDLE      = 3'd0;
  localparam logic [2:0] MS_SERVE     = 3'd1;
  localparam logic [2:0] MS_PLAY      = 3'd2;
  localparam logic [2:0] MS_POINT     = 3'd3;
  localparam logic [2:0] MS_GAME_OVER = 3'd4;

  localparam logic [10:0] LEFT_SCORE_OFFSET  = 11'd200;
  localparam logic [10:0] RIGHT_SCORE_OFFSET = 11'd420;

  function automatic logic [2:0] sat_inc(input logic [2:0] s, input logic [2:0] lim);
    return (s >= lim) ? lim : s + 3'd1;
  endfunction

endpackage

// File: rtl/match_controller_if.sv
// Match controller bus: frame/goal/start inputs and the score, display and ball-control outputs.
interface match_controller_if;
  logic       frame_tick;
  logic       start;
  logic       goal_left;
  logic       goal_right;
  logic [2:0] score_left;
  logic [2:0] score_right;
  logic       show_left;
  logic       show_right;
  logic       ball_reset;
  logic       serve_dir;
  logic       game_over;
  logic       winner;

  modport master (
    output frame_tick, start, goal_left, goal_right,
    input  score_left, score_right, show_left, show_right,
           ball_reset, serve_dir, game_over, winner
  );

  modport slave (
    input  frame_tick, start, goal_left, goal_right,
    output score_left, score_right, show_left, show_right,
           ball_reset, serve_dir, game_over, winner
  );
endinterface

// File: rtl/match_controller_frame_delay.sv
// 8-bit frame_tick counter: done pulses on the limit-th tick and the count restarts from 0.
module match_controller_frame_delay (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       tick,
  input  logic [7:0] limit,
  output logic       done
);
  logic [7:0] count;

  // done is independent of clear so callers may derive clear from done
  assign done = tick && (count == limit - 8'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (clear || done)
      count <= '0;
    else if (tick)
      count <= count + 8'd1;
  end
endmodule

// File: rtl/match_controller.sv
// Pong match sequencer: owns both scores and sequences IDLE/SERVE/PLAY/POINT/GAME_OVER,
// timing every hold period in frames.
module match_controller
  import match_controller_pkg::*;
#(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int BLINK_FRAMES = 30
) (
  input logic               clk,
  input logic               reset,
  match_controller_if.slave bus
);
  localparam logic [2:0] WIN = 3'(WIN_SCORE);

  logic [2:0] state;
  logic [2:0] score_l, score_r;
  logic       show_l, show_r, ball_rst, sdir, gover, win_r;
  logic       goal_any;
  logic       delay_tick, delay_clear, delay_done;
  logic       blink_tick, blink_clear, blink_done;
  logic [7:0] delay_limit;

  always_comb begin
    goal_any    = bus.goal_left | bus.goal_right;
    delay_tick  = bus.frame_tick && (state == MS_SERVE || state == MS_POINT);
    delay_limit = (state == MS_POINT) ? 8'(POINT_FRAMES) : 8'(SERVE_FRAMES);
    blink_tick  = bus.frame_tick && (state == MS_GAME_OVER);
    blink_clear = (state != MS_GAME_OVER);
    delay_clear = 1'b0;
    case (state)
      MS_IDLE, MS_GAME_OVER: delay_clear = bus.start;
      MS_SERVE, MS_POINT:    delay_clear = delay_done;
      MS_PLAY:               delay_clear = goal_any;
      default:               delay_clear = 1'b1;
    endcase
  end

  match_controller_frame_delay u_delay (
    .clk   (clk),
    .reset (reset),
    .clear (delay_clear),
    .tick  (delay_tick),
    .limit (delay_limit),
    .done  (delay_done)
  );

  match_controller_frame_delay u_blink (
    .clk   (clk),
    .reset (reset),
    .clear (blink_clear),
    .tick  (blink_tick),
    .limit (8'(BLINK_FRAMES)),
    .done  (blink_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= MS_IDLE;
      score_l  <= '0;
      score_r  <= '0;
      show_l   <= 1'b1;
      show_r   <= 1'b1;
      ball_rst <= 1'b1;
      sdir     <= 1'b0;
      gover    <= 1'b0;
      win_r    <= 1'b0;
    end else begin
      case (state)
        MS_IDLE: begin
          ball_rst <= 1'b1;
          if (bus.start) begin
            state   <= MS_SERVE;
            score_l <= '0;
            score_r <= '0;
          end
        end
        MS_SERVE: begin
          if (delay_done) begin
            state    <= MS_PLAY;
            ball_rst <= 1'b0;
          end
        end
        MS_PLAY: begin
          if (goal_any) begin
            state    <= MS_POINT;
            ball_rst <= 1'b1;
            // simultaneous goals cancel: no score, serve direction kept
            if (bus.goal_right && !bus.goal_left) begin
              score_l <= sat_inc(score_l, WIN);
              sdir    <= 1'b1;
            end else if (bus.goal_left && !bus.goal_right) begin
              score_r <= sat_inc(score_r, WIN);
              sdir    <= 1'b0;
            end
          end
        end
        MS_POINT: begin
          if (delay_done) begin
            if (score_l == WIN || score_r == WIN) begin
              state  <= MS_GAME_OVER;
              gover  <= 1'b1;
              win_r  <= (score_r == WIN);
              show_r <= (score_r != WIN);
              show_l <= (score_r == WIN);
            end else begin
              state <= MS_SERVE;
            end
          end
        end
        MS_GAME_OVER: begin
          if (bus.start) begin
            state  <= MS_IDLE;
            gover  <= 1'b0;
            show_l <= 1'b1;
            show_r <= 1'b1;
          end else if (blink_done) begin
            if (win_r) show_r <= ~show_r;
            else       show_l <= ~show_l;
          end
        end
        default: state <= MS_IDLE;
      endcase
    end
  end

  assign bus.score_left  = score_l;
  assign bus.score_right = score_r;
  assign bus.show_left   = show_l;
  assign bus.show_right  = show_r;
  assign bus.ball_reset  = ball_rst;
  assign bus.serve_dir   = sdir;
  assign bus.game_over   = gover;
  assign bus.winner      = win_r;
endmodule

// File: tb/tb_match_controller.sv
// Randomized self-checking bench for match_controller against a score/timing model
// derived from the match rules (frame counts, saturating scores, blink phase).
module tb_match_controller;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   ml, mr;      // model scores
  logic msd;         // model serve direction

  match_controller_if bus ();

  match_controller #(
    .WIN_SCORE    (7),
    .SERVE_FRAMES (60),
    .POINT_FRAMES (90),
    .BLINK_FRAMES (30)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // One-cycle stimulus; outputs are sampled on the negedge after the capturing posedge.
  task automatic cyc(input logic ft, input logic gl, input logic gr, input logic st);
    @(negedge clk);
    bus.frame_tick = ft; bus.goal_left = gl; bus.goal_right = gr; bus.start = st;
    @(negedge clk);
    bus.frame_tick = 1'b0; bus.goal_left = 1'b0; bus.goal_right = 1'b0; bus.start = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic chk_scores(input string tag);
    checks++;
    if (bus.score_left !== 3'(ml) || bus.score_right !== 3'(mr)) begin
      errors++;
      $display("FAIL %s scores: got %0d:%0d expected %0d:%0d", tag,
               bus.score_left, bus.score_right, ml, mr);
    end
  endtask

  task automatic chk_bit(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic test_reset;
    ml = 0; mr = 0; msd = 1'b0;
    chk_scores("reset");
    chk_bit("reset show_left", bus.show_left, 1'b1);
    chk_bit("reset show_right", bus.show_right, 1'b1);
    chk_bit("reset ball_reset", bus.ball_reset, 1'b1);
    chk_bit("reset serve_dir", bus.serve_dir, 1'b0);
    chk_bit("reset game_over", bus.game_over, 1'b0);
    chk_bit("reset winner", bus.winner, 1'b0);
  endtask

  // From IDLE or after a point: SERVE must hold exactly 60 ticks.
  task automatic test_serve;
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    ml = 0; mr = 0;
    chk_scores("serve entry");
    chk_bit("serve ball_reset", bus.ball_reset, 1'b1);
    ticks(59);
    chk_bit("serve tick59 ball_reset", bus.ball_reset, 1'b1);
    ticks(1);
    chk_bit("serve tick60 ball_reset", bus.ball_reset, 1'b0);
  endtask

  // One point scored from PLAY; right_scores means goal_left.
  task automatic play_point(input logic right_scores);
    ticks($urandom_range(0, 3));
    cyc(1'($urandom_range(0, 1)), right_scores, ~right_scores, 1'b0);
    if (right_scores) begin mr = (mr + 1 > 7) ? 7 : mr + 1; msd = 1'b0; end
    else              begin ml = (ml + 1 > 7) ? 7 : ml + 1; msd = 1'b1; end
    chk_scores("goal");
    chk_bit("goal serve_dir", bus.serve_dir, msd);
    chk_bit("goal ball_reset", bus.ball_reset, 1'b1);
    ticks(89);
    chk_bit("point tick89 game_over", bus.game_over, 1'b0);
    ticks(1);
    if (ml == 7 || mr == 7) begin
      chk_bit("match game_over", bus.game_over, 1'b1);
      chk_bit("match winner", bus.winner, logic'(mr == 7));
    end else begin
      chk_bit("point tick90 game_over", bus.game_over, 1'b0);
      ticks(59);
      chk_bit("reserve tick59 ball_reset", bus.ball_reset, 1'b1);
      ticks(1);
      chk_bit("reserve tick60 ball_reset", bus.ball_reset, 1'b0);
    end
  endtask

  task automatic test_both_goals;
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    chk_scores("both goals");
    chk_bit("both goals serve_dir", bus.serve_dir, msd);
    chk_bit("both goals ball_reset", bus.ball_reset, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk_scores("goal in POINT");
    ticks(90);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk_scores("goal in SERVE");
    ticks(59);
    chk_bit("serve after tie tick59", bus.ball_reset, 1'b1);
    ticks(1);
    chk_bit("serve after tie tick60", bus.ball_reset, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk_bit("start in PLAY ignored", bus.ball_reset, 1'b0);
  endtask

  task automatic test_random_match;
    int guard = 0;
    while (ml < 7 && mr < 7 && guard < 20) begin
      play_point(1'($urandom_range(0, 1)));
      guard++;
    end
    checks++;
    if (ml != 7 && mr != 7) begin
      errors++;
      $display("FAIL random match: no winner after %0d points", guard);
    end
  endtask

  task automatic test_blink;
    logic wr;
    logic exp_w;
    wr = logic'(mr == 7);
    for (int k = 0; k <= 90; k++) begin
      if (k > 0) ticks(1);
      if (k == 45) cyc(1'b0, 1'b1, 1'b0, 1'b0);
      exp_w = logic'((k / 30) % 2);
      chk_bit("blink winner show", wr ? bus.show_right : bus.show_left, exp_w);
      chk_bit("blink loser show", wr ? bus.show_left : bus.show_right, 1'b1);
    end
    chk_scores("game over scores held");
    chk_bit("game over held", bus.game_over, 1'b1);
  endtask

  task automatic test_restart;
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk_bit("restart game_over", bus.game_over, 1'b0);
    chk_bit("restart show_left", bus.show_left, 1'b1);
    chk_bit("restart show_right", bus.show_right, 1'b1);
    chk_bit("restart ball_reset", bus.ball_reset, 1'b1);
    test_serve();
  endtask

  task automatic test_reset_mid_play;
    play_point(1'b0); play_point(1'b1); play_point(1'b0);
    play_point(1'b1); play_point(1'b0);
    chk_scores("pre-reset 3:2");
    @(negedge clk);
    reset = 1'b1;
    #1;
    ml = 0; mr = 0;
    chk_scores("async reset");
    @(negedge clk);
    reset = 1'b0;
    chk_scores("after reset");
    chk_bit("after reset ball_reset", bus.ball_reset, 1'b1);
    chk_bit("after reset show_left", bus.show_left, 1'b1);
    chk_bit("after reset show_right", bus.show_right, 1'b1);
    chk_bit("after reset game_over", bus.game_over, 1'b0);
    ticks(100);
    chk_bit("idle ignores ticks", bus.ball_reset, 1'b1);
  endtask

  initial begin
    reset = 1'b1;
    bus.frame_tick = 1'b0; bus.goal_left = 1'b0; bus.goal_right = 1'b0; bus.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_serve();
    play_point(1'b0);
    test_both_goals();
    test_random_match();
    test_blink();
    test_restart();
    for (int i = 0; i < 7; i++) play_point(1'b0);
    test_blink();
    test_restart();
    test_reset_mid_play();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
